// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the Knight robot host-side remote (UART command link).
package remote_comm_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [7:0]  RESP_DONE = 8'hA5;
  localparam logic [7:0]  RESP_POS  = 8'h5A;
  localparam logic [15:0] CMD_CAL   = 16'h0000;

  localparam int BAUD_W = 12;
  localparam int BIT_W  = 4;

endpackage

// File: rtl/remote_comm_uart_tx.sv
// UART 8N1 byte serializer: trmt loads tx_data, tx_done pulses in the last cycle of the stop bit.
// A trmt coincident with tx_done reloads immediately, giving back-to-back frames with no idle gap.
module uart_tx
  import remote_comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [9:0]        shift_q, shift_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              busy_q, busy_d;
  logic              bit_end;

  assign bit_end = busy_q && (baud_q == BAUD_LAST);
  assign tx_done = bit_end && (bit_q == BIT_W'(9));
  // Idle shifter holds all ones, so the line is a plain flop output that idles high.
  assign tx      = shift_q[0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    if (trmt) begin
      shift_d = {1'b1, tx_data, 1'b0};
      baud_d  = '0;
      bit_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (bit_end) begin
        shift_d = {1'b1, shift_q[9:1]};
        baud_d  = '0;
        bit_d   = bit_q + 1'b1;
        busy_d  = !tx_done;
      end else begin
        baud_d  = baud_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignment so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Knight robot remote: sends 16-bit commands as two UART bytes (high first), receives response bytes.
// Optional REMOTE_COMM_BUSY_EN adds a busy output that is high while the TX FSM is not IDLE.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  input  logic        RX,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy
`ifdef REMOTE_COMM_BUSY_EN
  ,
  output logic        busy
`endif
);

  localparam logic [BAUD_W-1:0] RX_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] RX_FULL = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t   state_q, state_d;
  logic        accept, trmt, tx_done;
  logic [7:0]  tx_data;
  logic [7:0]  cmd_lo_q, cmd_lo_d;
  logic        cmd_snt_q, cmd_snt_d;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx      (TX),
    .tx_done (tx_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (snd_cmd) state_d = HIGH;
      HIGH:    if (tx_done) state_d = LOW;
      LOW:     if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The high byte goes straight from cmd on the accept edge; only the low byte needs holding.
  always_comb begin
    accept  = 1'b0;
    trmt    = 1'b0;
    tx_data = cmd_lo_q;
    case (state_q)
      IDLE: begin
        accept  = snd_cmd;
        trmt    = snd_cmd;
        tx_data = cmd[15:8];
      end
      HIGH:    trmt = tx_done;
      default: ;
    endcase
  end

  always_comb begin
    cmd_lo_d  = accept ? cmd[7:0] : cmd_lo_q;
    cmd_snt_d = cmd_snt_q;
    if (accept)                      cmd_snt_d = 1'b0;
    else if (state_q == LOW && tx_done) cmd_snt_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_lo_q  <= '0;
      cmd_snt_q <= 1'b0;
    end else begin
      cmd_lo_q  <= cmd_lo_d;
      cmd_snt_q <= cmd_snt_d;
    end
  end

  assign cmd_snt = cmd_snt_q;
`ifdef REMOTE_COMM_BUSY_EN
  assign busy = (state_q != IDLE);
`endif

  // RX: two-flop synchronizer plus one more stage for falling-edge detection.
  rx_state_t         rx_state_q, rx_state_d;
  logic              rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;
  logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
  logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        resp_q, resp_d;
  logic              resp_rdy_q, resp_rdy_d;
  logic              rdy_set, rdy_clr;

  assign rx_fall = rx_prev_q && !rx_sync_q;

  always_ff @(posedge clk) begin
    if (rst) rx_state_q <= RX_IDLE;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      RX_START: if (rx_baud_q == RX_HALF) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_baud_q == RX_FULL && rx_bit_q == BIT_W'(7)) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_baud_q == RX_FULL) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_baud_d  = rx_baud_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    resp_d     = resp_q;
    rdy_set    = 1'b0;
    rdy_clr    = accept;
    case (rx_state_q)
      RX_IDLE: begin
        rx_baud_d = '0;
        rx_bit_d  = '0;
        rdy_clr   = accept || rx_fall;
      end
      RX_START: if (rx_baud_q == RX_HALF) rx_baud_d = '0;
      RX_DATA: if (rx_baud_q == RX_FULL) begin
        rx_baud_d  = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
      end
      RX_STOP: if (rx_baud_q == RX_FULL) begin
        rx_baud_d = '0;
        if (rx_sync_q) begin
          resp_d  = rx_shift_q;
          rdy_set = 1'b1;
        end
      end
      default: ;
    endcase
    resp_rdy_d = rdy_set ? 1'b1 : (rdy_clr ? 1'b0 : resp_rdy_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: frame-level model of the command link and response receiver, checked every cycle.
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int CPB   = 16;
  localparam int HALF  = CPB / 2;
  localparam int FRAME = 10 * CPB;
  localparam int XFER  = 20 * CPB;
  localparam int MID   = 9 * CPB + HALF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = '0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        rx_line;
  logic        TX, cmd_snt, resp_rdy;
  logic [7:0]  resp;
`ifdef REMOTE_COMM_BUSY_EN
  logic        busy;
`endif

  assign rx_line = loop_en ? TX : rx_drv;

  remote_comm #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .TX       (TX),
    .RX       (rx_line),
    .cmd_snt  (cmd_snt),
    .resp     (resp),
    .resp_rdy (resp_rdy)
`ifdef REMOTE_COMM_BUSY_EN
    ,
    .busy     (busy)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int         s;
    logic [7:0] data;
    bit         stop_ok;
    bit         glitch;
  } frame_t;

  frame_t      frames[$];
  bit          m_active = 1'b0;
  int          m_acc = 0;
  logic [15:0] m_cmd = '0;
  logic        m_snt = 1'b0;
  logic [7:0]  m_resp = '0;
  logic        m_rdy = 1'b0;

  // Bit idx (0..19) of the two back-to-back 8N1 frames for command c.
  function automatic logic frame_bit(input logic [15:0] c, input int idx);
    logic [7:0] b;
    int j;
    b = (idx < 10) ? c[15:8] : c[7:0];
    j = idx % 10;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  always @(posedge clk) begin : model
    int k;
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_snt    = 1'b0;
      m_resp   = '0;
      m_rdy    = 1'b0;
      frames.delete();
    end else begin
      if (m_active && cyc - m_acc == XFER) m_snt = 1'b1;
      if (snd_cmd && (!m_active || cyc - m_acc > XFER)) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_cmd    = cmd;
        m_snt    = 1'b0;
        m_rdy    = 1'b0;
        if (loop_en) begin
          frames.push_back('{cyc, cmd[15:8], 1'b1, 1'b0});
          frames.push_back('{cyc + FRAME, cmd[7:0], 1'b1, 1'b0});
        end
      end
      for (int i = frames.size() - 1; i >= 0; i--) begin
        k = cyc - frames[i].s;
        if (k == 6) m_rdy = 1'b0;
        if (!frames[i].glitch && frames[i].stop_ok && k == MID + 6) begin
          m_resp = frames[i].data;
          m_rdy  = 1'b1;
        end
        if ((frames[i].glitch && k > 6) || k > MID + 6) frames.delete(i);
      end
    end
  end

  // Response outputs are don't-care only near the start-bit edge and the mid-stop sample point.
  always @(negedge clk) begin : compare
    int  k, k2;
    bit  dc;
    logic exp_tx;
    if (cyc > 0) begin
      k = cyc - m_acc;
      exp_tx = 1'b1;
      if (m_active && k < XFER) exp_tx = frame_bit(m_cmd, k / CPB);
      check("tx", TX, exp_tx);
      check("cmd_snt", cmd_snt, m_snt);
`ifdef REMOTE_COMM_BUSY_EN
      check("busy", busy, m_active && k < XFER);
`endif
      dc = 1'b0;
      foreach (frames[i]) begin
        k2 = cyc - frames[i].s;
        if (k2 >= 1 && k2 <= 5) dc = 1'b1;
        if (!frames[i].glitch && k2 >= MID - 2 && k2 <= MID + 5) dc = 1'b1;
      end
      if (!dc) begin
        check("resp", resp, m_resp);
        check("resp_rdy", resp_rdy, m_rdy);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] c, output int acc);
    cmd     = c;
    snd_cmd = 1'b1;
    tick();
    acc     = cyc;
    snd_cmd = 1'b0;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) tick();
  endtask

  task automatic wait_snt(input int acc, input string name);
    int n = 0;
    int lat;
    while (cmd_snt !== 1'b1 && n < 25 * CPB) begin
      tick();
      n++;
    end
    if (cmd_snt !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: cmd_snt never rose within %0d cycles", name, 25 * CPB);
    end else begin
      lat = cyc - acc;
      check(name, lat, (lat == XFER + 1) ? XFER + 1 : XFER);
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_b);
    logic [9:0] f;
    f = {stop_b, d, 1'b0};
    frames.push_back('{cyc, d, stop_b, 1'b0});
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (CPB) tick();
    end
    rx_drv = 1'b1;
  endtask

  task automatic capture(input int acc, output logic [19:0] bits);
    for (int j = 0; j < 20; j++) begin
      wait_until(acc + j * CPB + HALF);
      @(negedge clk);
      bits[j] = TX;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int acc;
    logic [19:0] bits;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    check("rst_tx", TX, 1'b1);
    check("rst_cmd_snt", cmd_snt, 1'b0);
    check("rst_resp", resp, 8'h00);
    check("rst_resp_rdy", resp_rdy, 1'b0);

    // 1: command 0x4022, decoded from the line independently of the model
    tick();
    send(16'h4022, acc);
    capture(acc, bits);
    check("t1_start_hi", bits[0], 1'b0);
    check("t1_byte_hi", bits[8:1], 8'h40);
    check("t1_stop_hi", bits[9], 1'b1);
    check("t1_start_lo", bits[10], 1'b0);
    check("t1_byte_lo", bits[18:11], 8'h22);
    check("t1_stop_lo", bits[19], 1'b1);
    wait_snt(acc, "t1_latency");

    // 2: loopback, 0x00 then 0xA5 are both received; last one stays
    loop_en = 1'b1;
    tick();
    send(16'h00A5, acc);
    wait_snt(acc, "t2_latency");
    check("t2_resp", resp, RESP_DONE);
    check("t2_resp_rdy", resp_rdy, 1'b1);
    repeat (50) tick();
    check("t2_cmd_snt_held", cmd_snt, 1'b1);
    loop_en = 1'b0;

    // 3: response arrives mid-transmit
    tick();
    send(16'hC3E1, acc);
    wait_until(acc + 40);
    drive_frame(RESP_POS, 1'b1);
    wait_snt(acc, "t3_latency");
    check("t3_resp", resp, RESP_POS);
    check("t3_resp_rdy", resp_rdy, 1'b1);

    // 4: snd_cmd with a new word mid-transfer is ignored
    tick();
    send(16'h3C0F, acc);
    wait_until(acc + 50);
    cmd     = 16'h1234;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    wait_snt(acc, "t4_latency");
    repeat (40) tick();
    check("t4_tx_idle", TX, 1'b1);
    check("t4_cmd_snt", cmd_snt, 1'b1);

    // 5: glitch, framing error, then a good frame
    repeat (10) tick();
    frames.push_back('{cyc, 8'h00, 1'b0, 1'b1});
    rx_drv = 1'b0;
    repeat (CPB / 4) tick();
    rx_drv = 1'b1;
    repeat (3 * CPB) tick();
    check("t5_glitch_rdy", resp_rdy, 1'b0);
    drive_frame(8'h3C, 1'b0);
    repeat (2 * CPB) tick();
    check("t5_ferr_resp", resp, RESP_POS);
    check("t5_ferr_rdy", resp_rdy, 1'b0);
    drive_frame(8'h81, 1'b1);
    repeat (CPB) tick();
    check("t5_good_resp", resp, 8'h81);
    check("t5_good_rdy", resp_rdy, 1'b1);

    // 6: reset in the middle of the low byte, then a fresh command
    send(16'hBEEF, acc);
    wait_until(acc + 5);
    drive_frame(8'h66, 1'b1);
    check("t6_pre_rdy", resp_rdy, 1'b1);
    check("t6_pre_resp", resp, 8'h66);
    wait_until(acc + 13 * CPB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_tx", TX, 1'b1);
    check("t6_rst_cmd_snt", cmd_snt, 1'b0);
    check("t6_rst_rdy", resp_rdy, 1'b0);
    tick();
    send(16'h0102, acc);
    wait_snt(acc, "t6_latency");
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
